// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: synchronizes the panel lines, shifts serial RGB into a capture row,
// and on latch hands the row to a drain buffer that streams out column by column.
module hub75_rx_capture #(
  parameter int hpixel_p      = 64,
  parameter int segments_p    = 2,
  parameter int row_width_p   = 5,
  parameter int sync_stages_p = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_serial_clk,
  input  logic [segments_p-1:0]         i_red,
  input  logic [segments_p-1:0]         i_green,
  input  logic [segments_p-1:0]         i_blue,
  input  logic                          i_latch_en,
  input  logic [row_width_p-1:0]        i_row_addr,
  input  logic                          i_clr_err,
  output logic                          o_wr_valid,
  input  logic                          i_wr_ready,
  output logic [row_width_p-1:0]        o_wr_row,
  output logic [$clog2(hpixel_p)-1:0]   o_wr_col,
  output logic [segments_p-1:0][2:0]    o_wr_data,
  output logic                          o_wr_last,
  output logic [$clog2(hpixel_p+1)-1:0] o_bit_cnt,
  output logic                          o_err_len,
  output logic                          o_err_ovf,
  output logic                          o_err_drop
);

  localparam int CW = $clog2(hpixel_p);
  localparam int BW = $clog2(hpixel_p + 1);
  localparam int IW = 2 + 3 * segments_p + row_width_p;
  localparam logic [CW-1:0] LAST_COL = CW'(hpixel_p - 1);
  localparam logic [BW-1:0] FULL_CNT = BW'(hpixel_p);

  typedef logic [segments_p-1:0][2:0] pix_t;
  typedef pix_t [hpixel_p-1:0]        line_t;
  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  // All HUB75 lines travel through one shared synchronizer so they stay aligned.
  logic [sync_stages_p-1:0][IW-1:0] r_sync;
  logic [IW-1:0]                    w_in;
  logic [IW-1:0]                    w_s;
  logic                             w_s_serial;
  logic                             w_s_latch;
  logic [row_width_p-1:0]           w_s_row;
  pix_t                             w_pix;

  assign w_in       = {i_serial_clk, i_latch_en, i_red, i_green, i_blue, i_row_addr};
  assign w_s        = r_sync[sync_stages_p-1];
  assign w_s_serial = w_s[IW-1];
  assign w_s_latch  = w_s[IW-2];
  assign w_s_row    = w_s[row_width_p-1:0];

  // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_pix = '0;
    for (int s = 0; s < segments_p; s++) begin
      w_pix[s] = {w_s[IW-3-(segments_p-1)+s],
                  w_s[IW-3-segments_p-(segments_p-1)+s],
                  w_s[IW-3-2*segments_p-(segments_p-1)+s]};
    end
  end

  logic         r_serial_prev;
  logic         r_latch_prev;
  logic         w_ser_rise;
  logic         w_lat_rise;
  logic         w_store;
  logic [BW-1:0] w_cnt_post;
  logic [BW-1:0] r_bit_cnt;
  line_t        r_cap;
  line_t        r_drn;
  line_t        w_cap_next;
  logic [row_width_p-1:0] r_drn_row;
  logic         r_err_len;
  logic         r_err_ovf;
  logic         r_err_drop;
  state_t       r_state;
  state_t       w_state_next;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_col_next;

  assign w_ser_rise = w_s_serial & ~r_serial_prev;
  assign w_lat_rise = w_s_latch & ~r_latch_prev;
  assign w_store    = w_ser_rise & (r_bit_cnt != FULL_CNT);
  assign w_cnt_post = r_bit_cnt + BW'(w_store);

  // The row handed over on latch already contains a bit stored in the same cycle.
  always_comb begin
    w_cap_next = r_cap;
    if (w_store) w_cap_next[r_bit_cnt[CW-1:0]] = w_pix;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[sync_stages_p-2:0], w_in};
    end
  end

  // NOTE: the row buffers are reset because unwritten columns must read back as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_serial_prev <= 1'b0;
      r_latch_prev  <= 1'b0;
      r_cap         <= '0;
      r_drn         <= '0;
      r_drn_row     <= '0;
      r_bit_cnt     <= '0;
      r_err_len     <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_drop    <= 1'b0;
    end else begin
      r_serial_prev <= w_s_serial;
      r_latch_prev  <= w_s_latch;
      if (w_lat_rise) begin
        if (r_state == S_IDLE) begin
          r_drn     <= w_cap_next;
          r_drn_row <= w_s_row;
        end
        r_cap     <= '0;
        r_bit_cnt <= '0;
      end else begin
        r_cap     <= w_cap_next;
        r_bit_cnt <= w_cnt_post;
      end
      r_err_len  <= (r_err_len & ~i_clr_err) | (w_lat_rise & (w_cnt_post != FULL_CNT));
      r_err_ovf  <= (r_err_ovf & ~i_clr_err) | (w_ser_rise & (r_bit_cnt == FULL_CNT));
      r_err_drop <= (r_err_drop & ~i_clr_err) | (w_lat_rise & (r_state != S_IDLE));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    case (r_state)
      S_IDLE: begin
        w_col_next = '0;
        if (w_lat_rise) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_wr_ready) begin
          if (r_col == LAST_COL) begin
            w_state_next = S_IDLE;
            w_col_next   = '0;
          end else begin
            w_col_next = r_col + CW'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_wr_valid = (r_state == S_DRAIN);
  assign o_wr_col   = r_col;
  assign o_wr_row   = r_drn_row;
  assign o_wr_data  = o_wr_valid ? r_drn[r_col] : '0;
  assign o_wr_last  = o_wr_valid & (r_col == LAST_COL);
  assign o_bit_cnt  = r_bit_cnt;
  assign o_err_len  = r_err_len;
  assign o_err_ovf  = r_err_ovf;
  assign o_err_drop = r_err_drop;

endmodule
